// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array feeder.
package systolic_pkg;

   localparam int unsigned DEF_N      = 4;
   localparam int unsigned DEF_DWIDTH = 32;
   localparam int unsigned DEF_KCNT_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2,
      DONE   = 2'd3
   } feeder_state_t;

   // Cycles after the last accept until PE(N-1,N-1) holds its final product.
   function automatic int unsigned flush_len(input int unsigned n);
      return (2 * n) - 1;
   endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth always-shifting delay line with synchronous active-low reset.
module skew_line #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned DEPTH  = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DWIDTH-1:0] din_i,
   output logic [DWIDTH-1:0] dout_o
);

   logic [DWIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned s = 0; s < DEPTH; s++) begin
            stage_q[s] <= '0;
         end
      end else begin
         stage_q[0] <= din_i;
         for (int unsigned s = 1; s < DEPTH; s++) begin
            stage_q[s] <= stage_q[s-1];
         end
      end
   end

   assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Feeds k-slices of A and B into an N x N systolic array with per-lane skew,
// drives the array-wide PE enable and flags when all accumulators are final.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned N      = DEF_N,
   parameter int unsigned DWIDTH = DEF_DWIDTH,
   parameter int unsigned KCNT_W = DEF_KCNT_W
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_last,
   input  logic [N*DWIDTH-1:0]   a_vec,
   input  logic [N*DWIDTH-1:0]   b_vec,
   output logic [N*DWIDTH-1:0]   west_out,
   output logic [N*DWIDTH-1:0]   north_out,
   output logic                  pe_en,
   output logic                  busy,
   output logic                  done,
   output logic [KCNT_W-1:0]     k_count
);

   localparam int unsigned VEC_W     = N * DWIDTH;
   localparam int unsigned FLUSH_LEN = flush_len(N);
   localparam int unsigned FLUSH_W   = $clog2(FLUSH_LEN);

   feeder_state_t      state_q, state_d;
   logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [KCNT_W-1:0]  k_count_q, k_count_d;
   logic               in_ready_q, in_ready_d;
   logic               pe_en_q, pe_en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               accept_c;
   logic [VEC_W-1:0]   west_in_c;
   logic [VEC_W-1:0]   north_in_c;

   // Next-state, counters and registered-output decode.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      k_count_d   = k_count_q;
      accept_c    = in_valid && in_ready_q;
      // Bubbles and non-streaming cycles shift zeros so skew is kept and products are 0.
      west_in_c   = accept_c ? a_vec : '0;
      north_in_c  = accept_c ? b_vec : '0;

      case (state_q)
         IDLE: begin
            if (accept_c) begin
               k_count_d   = KCNT_W'(1);
               flush_cnt_d = '0;
               state_d     = in_last ? FLUSH : STREAM;
            end
         end
         STREAM: begin
            if (accept_c) begin
               if (k_count_q != '1) begin
                  k_count_d = k_count_q + KCNT_W'(1);
               end
               if (in_last) begin
                  flush_cnt_d = '0;
                  state_d     = FLUSH;
               end
            end
         end
         FLUSH: begin
            if (flush_cnt_q == FLUSH_W'(FLUSH_LEN - 1)) begin
               state_d = DONE;
            end else begin
               flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d = (state_d == IDLE) || (state_d == STREAM);
      pe_en_d    = (state_d == STREAM) || (state_d == FLUSH);
      busy_d     = pe_en_d;
      done_d     = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         flush_cnt_q <= '0;
         k_count_q   <= '0;
         in_ready_q  <= 1'b1;
         pe_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         k_count_q   <= k_count_d;
         in_ready_q  <= in_ready_d;
         pe_en_q     <= pe_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Lane i of both edges is delayed by i cycles on top of the input register.
   for (genvar i = 0; i < N; i++) begin : g_lane
      skew_line #(
         .DWIDTH (DWIDTH),
         .DEPTH  (i + 1)
      ) u_west (
         .clk    (clk),
         .rstn   (rstn),
         .din_i  (west_in_c[i*DWIDTH +: DWIDTH]),
         .dout_o (west_out[i*DWIDTH +: DWIDTH])
      );

      skew_line #(
         .DWIDTH (DWIDTH),
         .DEPTH  (i + 1)
      ) u_north (
         .clk    (clk),
         .rstn   (rstn),
         .din_i  (north_in_c[i*DWIDTH +: DWIDTH]),
         .dout_o (north_out[i*DWIDTH +: DWIDTH])
      );
   end

   assign in_ready = in_ready_q;
   assign pe_en    = pe_en_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign k_count  = k_count_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a timing scoreboard and a 4x4 PE array model.
module tb_systolic_skew_feeder;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int KW = 16;
   localparam int VW = N * DW;

   logic          clk;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic          in_last;
   logic [VW-1:0] a_vec;
   logic [VW-1:0] b_vec;
   logic [VW-1:0] west_out;
   logic [VW-1:0] north_out;
   logic          pe_en;
   logic          busy;
   logic          done;
   logic [KW-1:0] k_count;

   systolic_skew_feeder #(.N(N), .DWIDTH(DW), .KCNT_W(KW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .a_vec     (a_vec),
      .b_vec     (b_vec),
      .west_out  (west_out),
      .north_out (north_out),
      .pe_en     (pe_en),
      .busy      (busy),
      .done      (done),
      .k_count   (k_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_on = 1'b0;
   bit arr_clr = 1'b0;

   typedef struct {
      int            c;
      int            lane;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } ent_t;

   ent_t          sb[$];
   int            done_q[$];
   int            en_lo  = 1;
   int            en_hi  = 0;
   int            rdy_lo = 1;
   int            rdy_hi = 0;
   bit            in_job = 1'b0;
   logic [KW-1:0] kc     = '0;
   int            gap[4];

   logic [DW-1:0] acc [N][N];
   logic [DW-1:0] wq  [N][N];
   logic [DW-1:0] nq  [N][N];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transaction model: pushes expected lane values, done cycle and enable windows on accept.
   always @(posedge clk) begin : model
      ent_t e;
      if (!rstn) begin
         sb.delete();
         done_q.delete();
         en_lo = 1; en_hi = 0; rdy_lo = 1; rdy_hi = 0;
         kc = '0; in_job = 1'b0;
      end else if (in_valid && !(cyc >= rdy_lo && cyc <= rdy_hi)) begin
         if (!in_job) begin
            kc = KW'(1); en_lo = cyc + 1; en_hi = 32'h3fff_ffff; in_job = 1'b1;
         end else if (kc != '1) begin
            kc = kc + KW'(1);
         end
         for (int i = 0; i < N; i++) begin
            e.c = cyc + 1 + i; e.lane = i;
            e.a = a_vec[i*DW +: DW]; e.b = b_vec[i*DW +: DW];
            sb.push_back(e);
         end
         if (in_last) begin
            en_hi = cyc + 2*N - 1; rdy_lo = cyc + 1; rdy_hi = cyc + 2*N;
            done_q.push_back(cyc + 2*N);
            in_job = 1'b0;
         end
      end
   end

   // Downstream PE array: west forwarded east, north forwarded south, acc += w*n.
   always @(posedge clk) begin : pe_array
      logic [DW-1:0] w, n;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (arr_clr || !rstn) begin
               acc[i][j] <= '0; wq[i][j] <= '0; nq[i][j] <= '0;
            end else if (pe_en) begin
               if (j == 0) w = west_out[i*DW +: DW]; else w = wq[i][j-1];
               if (i == 0) n = north_out[j*DW +: DW]; else n = nq[i-1][j];
               acc[i][j] <= acc[i][j] + w * n;
               wq[i][j]  <= w;
               nq[i][j]  <= n;
            end
         end
      end
   end

   // Per-cycle monitor comparing DUT outputs against the scoreboard.
   always @(negedge clk) begin : mon
      int            idx;
      logic [DW-1:0] ea, eb;
      bit            ed;
      if (mon_on) begin
         for (int i = 0; i < N; i++) begin
            idx = -1; ea = '0; eb = '0;
            for (int k = 0; k < sb.size(); k++) begin
               if (sb[k].c == cyc && sb[k].lane == i) idx = k;
            end
            if (idx >= 0) begin
               ea = sb[idx].a; eb = sb[idx].b;
               sb.delete(idx);
            end
            chk($sformatf("west_lane%0d_c%0d", i, cyc), west_out[i*DW +: DW], ea);
            chk($sformatf("north_lane%0d_c%0d", i, cyc), north_out[i*DW +: DW], eb);
         end
         chk($sformatf("pe_en_c%0d", cyc), pe_en, (cyc >= en_lo && cyc <= en_hi));
         chk($sformatf("busy_c%0d", cyc), busy, (cyc >= en_lo && cyc <= en_hi));
         ed = (done_q.size() > 0) && (done_q[0] == cyc);
         if (ed) void'(done_q.pop_front());
         chk($sformatf("done_c%0d", cyc), done, ed);
         chk($sformatf("in_ready_c%0d", cyc), in_ready, !(cyc >= rdy_lo && cyc <= rdy_hi));
         chk($sformatf("k_count_c%0d", cyc), k_count, kc);
      end
   end

   task automatic wait_done(input int budget, output int dc);
      dc = -1;
      for (int n = 0; n < budget; n++) begin
         if (done === 1'b1) begin
            dc = cyc;
            break;
         end
         step();
      end
      if (dc < 0) chk("done_timeout", 64'd0, 64'd1);
   endtask

   // A = identity, B[k][j] = 10k+j, four slices with optional bubbles before slices 1..3.
   task automatic run_ab_job(input bit use_gaps, output int first, output int dc);
      arr_clr = 1'b1; step(); arr_clr = 1'b0;
      first = 0;
      for (int k = 0; k < N; k++) begin
         if (use_gaps) begin
            in_valid = 1'b0;
            repeat (gap[k]) step();
         end
         for (int i = 0; i < N; i++) begin
            a_vec[i*DW +: DW] = (i == k) ? DW'(1) : DW'(0);
            b_vec[i*DW +: DW] = DW'(10 * k + i);
         end
         in_valid = 1'b1;
         in_last  = (k == N - 1);
         if (k == 0) first = cyc;
         step();
      end
      in_valid = 1'b0; in_last = 1'b0;
      wait_done(60, dc);
   endtask

   initial begin
      int f, dc;
      rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0; a_vec = '0; b_vec = '0;
      repeat (3) step();
      rstn = 1'b1;
      mon_on = 1'b1;
      chk("rst_west", west_out, 0);
      chk("rst_north", north_out, 0);
      chk("rst_pe_en", pe_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_k_count", k_count, 0);
      step();
      chk("rst_in_ready", in_ready, 1);
      repeat (20) step();
      chk("idle_pe_en", pe_en, 0);

      // Single-slice skew job.
      a_vec = {32'd4, 32'd3, 32'd2, 32'd1};
      b_vec = {32'd8, 32'd7, 32'd6, 32'd5};
      in_valid = 1'b1; in_last = 1'b1; f = cyc;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      chk("skew_west0_F1", west_out[0 +: DW], 1);
      chk("skew_north0_F1", north_out[0 +: DW], 5);
      repeat (3) step();
      chk("skew_west3_F4", west_out[3*DW +: DW], 4);
      chk("skew_north3_F4", north_out[3*DW +: DW], 8);
      wait_done(40, dc);
      chk("skew_done_latency", dc - f, 8);
      step();

      // Back-to-back 4x4 job.
      run_ab_job(1'b0, f, dc);
      chk("full_done_latency", dc - f, 2*N + 3);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            chk($sformatf("full_pe_%0d_%0d", i, j), acc[i][j], 10*i + j);
      chk("full_k_count", k_count, 4);
      step();

      // Same job with three bubbles scattered between slices.
      gap = '{0, 0, 0, 0};
      repeat (3) gap[$urandom_range(1, 3)]++;
      run_ab_job(1'b1, f, dc);
      chk("bub_done_latency", dc - f, 2*N + 3 + 3);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            chk($sformatf("bub_pe_%0d_%0d", i, j), acc[i][j], 10*i + j);
      chk("bub_k_count", k_count, 4);
      step();

      // Backpressure: valid held through FLUSH and DONE.
      a_vec = {32'd1, 32'd1, 32'd1, 32'd1};
      b_vec = {32'd2, 32'd2, 32'd2, 32'd2};
      in_valid = 1'b1; in_last = 1'b1;
      step();
      a_vec = {32'd9, 32'd9, 32'd9, 32'd9};
      for (int n = 0; n < 2*N; n++) begin
         chk($sformatf("bp_in_ready_%0d", n), in_ready, 0);
         step();
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("bp_k_count", k_count, 1);
      chk("bp_ready_back", in_ready, 1);
      step();

      // Reset after two slices, with a handshake offered during reset.
      a_vec = {32'd5, 32'd6, 32'd7, 32'd8};
      b_vec = {32'd1, 32'd2, 32'd3, 32'd4};
      in_valid = 1'b1; in_last = 1'b0;
      repeat (2) step();
      rstn = 1'b0; in_last = 1'b1;
      step();
      rstn = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      chk("mrst_west", west_out, 0);
      chk("mrst_north", north_out, 0);
      chk("mrst_pe_en", pe_en, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk("mrst_k_count", k_count, 0);
      chk("mrst_in_ready", in_ready, 1);
      repeat (10) step();

      // Fresh single-slice job: outer product a_i * b_j.
      arr_clr = 1'b1; step(); arr_clr = 1'b0;
      a_vec = {32'd4, 32'd3, 32'd2, 32'd1};
      b_vec = {32'd5, 32'd4, 32'd3, 32'd2};
      in_valid = 1'b1; in_last = 1'b1; f = cyc;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      wait_done(40, dc);
      chk("fresh_done_latency", dc - f, 8);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            chk($sformatf("fresh_pe_%0d_%0d", i, j), acc[i][j], (i + 1) * (j + 2));
      chk("fresh_k_count", k_count, 1);

      repeat (3) step();
      chk("sb_drained", sb.size(), 0);
      chk("done_q_drained", done_q.size(), 0);
      mon_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
